// File: rtl/alu_8bit_arbiter.sv
// Two-requester round-robin front end for a shared combinational alu_8bit.
// Grants one operation at a time, holds the ALU inputs for EXEC_CYCLES,
// captures the result and returns it on a tagged response channel.
module alu_8bit_arbiter #(
    parameter int EXEC_CYCLES = 1,     // 1..15
    parameter bit DIV_GUARD   = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [15:0] req_a,
    input  logic [15:0] req_b,
    input  logic [7:0]  req_op,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic [3:0]  alu_sel,
    input  logic [7:0]  alu_out,
    input  logic        alu_cout,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [7:0]  rsp_data,
    output logic        rsp_cout,
    output logic        rsp_err,
    output logic        busy,
    output logic [15:0] done_count,
    output logic [7:0]  err_count
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t      r_state, w_state_nxt;
    logic        r_last_grant;
    logic        r_id;
    logic [3:0]  r_exec_cnt;
    logic [7:0]  r_alu_a, r_alu_b;
    logic [3:0]  r_alu_sel;
    logic        r_rsp_valid, r_rsp_id, r_rsp_cout, r_rsp_err;
    logic [7:0]  r_rsp_data;
    logic [15:0] r_done_count;
    logic [7:0]  r_err_count;

    logic        w_gnt_any, w_gnt_id, w_accept, w_div0, w_handoff;
    logic [7:0]  w_a, w_b;
    logic [3:0]  w_op;

    // Round-robin pick: on a tie the requester that did not win last time goes.
    always_comb begin
        w_gnt_any = |req_valid;
        w_gnt_id  = (req_valid == 2'b11) ? ~r_last_grant : req_valid[1];
        w_a       = w_gnt_id ? req_a[15:8] : req_a[7:0];
        w_b       = w_gnt_id ? req_b[15:8] : req_b[7:0];
        w_op      = w_gnt_id ? req_op[7:4] : req_op[3:0];
        w_div0    = DIV_GUARD && (w_op == 4'b0011) && (w_b == 8'h00);
    end

    // Next state and handshake strobes; ready is only offered from IDLE.
    always_comb begin
        w_state_nxt = r_state;
        req_ready   = 2'b00;
        w_accept    = 1'b0;
        w_handoff   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_gnt_any && rst_n) begin
                    req_ready   = w_gnt_id ? 2'b10 : 2'b01;
                    w_accept    = 1'b1;
                    w_state_nxt = w_div0 ? RESP : EXEC;
                end
            end
            EXEC: begin
                if (r_exec_cnt == 4'd0) w_state_nxt = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    w_handoff   = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    // Datapath: operand registers, result capture, counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_last_grant <= 1'b1;
            r_id         <= 1'b0;
            r_exec_cnt   <= 4'd0;
            r_alu_a      <= 8'h00;
            r_alu_b      <= 8'h00;
            r_alu_sel    <= 4'h0;
            r_rsp_valid  <= 1'b0;
            r_rsp_id     <= 1'b0;
            r_rsp_data   <= 8'h00;
            r_rsp_cout   <= 1'b0;
            r_rsp_err    <= 1'b0;
            r_done_count <= 16'h0000;
            r_err_count  <= 8'h00;
        end else begin
            if (w_accept) begin
                r_alu_a      <= w_a;
                r_alu_b      <= w_b;
                r_alu_sel    <= w_op;
                r_id         <= w_gnt_id;
                r_last_grant <= w_gnt_id;
                r_exec_cnt   <= 4'(EXEC_CYCLES - 1);
                if (w_div0) begin
                    // Rejected op skips EXEC and answers with an error response.
                    r_rsp_valid <= 1'b1;
                    r_rsp_id    <= w_gnt_id;
                    r_rsp_data  <= 8'h00;
                    r_rsp_cout  <= 1'b0;
                    r_rsp_err   <= 1'b1;
                    if (r_err_count != 8'hFF) r_err_count <= r_err_count + 8'd1;
                end
            end
            if (r_state == EXEC) begin
                if (r_exec_cnt == 4'd0) begin
                    r_rsp_valid <= 1'b1;
                    r_rsp_id    <= r_id;
                    r_rsp_data  <= alu_out;
                    r_rsp_cout  <= alu_cout;
                    r_rsp_err   <= 1'b0;
                end else begin
                    r_exec_cnt <= r_exec_cnt - 4'd1;
                end
            end
            if (w_handoff) begin
                r_rsp_valid  <= 1'b0;
                r_done_count <= r_done_count + 16'd1;
            end
        end
    end

    assign alu_a      = r_alu_a;
    assign alu_b      = r_alu_b;
    assign alu_sel    = r_alu_sel;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_id     = r_rsp_id;
    assign rsp_data   = r_rsp_data;
    assign rsp_cout   = r_rsp_cout;
    assign rsp_err    = r_rsp_err;
    assign busy       = (r_state != IDLE);
    assign done_count = r_done_count;
    assign err_count  = r_err_count;

endmodule
